// File: rtl/sram_ctrl_pkg.sv
// Shared state encoding, counter widths and strobe decode for the external SRAM controller.
package sram_ctrl_pkg;

    localparam int CNT_W  = 4;
    localparam int TURN_W = 2;

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] SETUP    = 3'd1;
    localparam logic [2:0] WR_PULSE = 3'd2;
    localparam logic [2:0] WR_HOLD  = 3'd3;
    localparam logic [2:0] TURN     = 3'd4;
    localparam logic [2:0] RD_PULSE = 3'd5;

    typedef struct packed {
        logic ce_n;
        logic oe_n;
        logic we_n;
        logic dq_oe;
    } strobe_t;

    // Pad strobes for a given state; registered by the caller so pads never glitch.
    function automatic strobe_t strobe_decode(input logic [2:0] st, input logic is_wr);
        strobe_t s;
        s = '{ce_n: 1'b1, oe_n: 1'b1, we_n: 1'b1, dq_oe: 1'b0};
        case (st)
            SETUP: begin
                s.ce_n  = 1'b0;
                s.oe_n  = is_wr;
                s.dq_oe = is_wr;
            end
            WR_PULSE: begin
                s.ce_n  = 1'b0;
                s.we_n  = 1'b0;
                s.dq_oe = 1'b1;
            end
            WR_HOLD: begin
                s.ce_n  = 1'b0;
                s.dq_oe = 1'b1;
            end
            RD_PULSE: begin
                s.ce_n = 1'b0;
                s.oe_n = 1'b0;
            end
            default: ;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/sram_ctrl_dq_io.sv
// Bidirectional SRAM data pad array: SB_IO cells under SYNTHESIS (yosys/iCE40),
// behavioural tristate model otherwise.
module sram_ctrl_dq_io #(
    parameter int DATA_W = 8
) (
    inout  wire  [DATA_W-1:0] dq_pad,
    input  logic              dq_oe,
    input  logic [DATA_W-1:0] dq_out,
    output logic [DATA_W-1:0] dq_in
);

`ifdef SYNTHESIS
    // Unregistered tristate output, unregistered input, no pull-up.
    for (genvar i = 0; i < DATA_W; i++) begin : g_pad
        SB_IO #(
            .PIN_TYPE(6'b101001),
            .PULLUP  (1'b0)
        ) u_io (
            .PACKAGE_PIN  (dq_pad[i]),
            .OUTPUT_ENABLE(dq_oe),
            .D_OUT_0      (dq_out[i]),
            .D_IN_0       (dq_in[i])
        );
    end
`else
    assign dq_pad = dq_oe ? dq_out : {DATA_W{1'bz}};
    assign dq_in  = dq_pad;
`endif

endmodule

// File: rtl/sram_ctrl.sv
// Asynchronous SRAM controller with registered strobes, wait states, write hold and turnaround.
// Define SRAM_CTRL_INPUT_SYNC_EN to add a register stage on sram_dq_in before read capture.
module sram_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int ADDR_W      = 19,
    parameter int DATA_W      = 8,
    parameter int WAIT_STATES = 1,
    parameter int TURN_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              busy,
    output logic [ADDR_W-1:0] sram_addr,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic              sram_dq_oe,
    output logic [DATA_W-1:0] sram_dq_out,
    input  logic [DATA_W-1:0] sram_dq_in
);

    logic [2:0]        state, state_nx;
    logic [CNT_W-1:0]  cnt, cnt_nx;
    logic [TURN_W-1:0] turn_cnt, turn_nx;
    logic              op_we, op_we_nx;
    logic              rd_extra, rd_extra_nx;
    logic              rd_done, rd_pend;
    logic              accept;
    logic [DATA_W-1:0] cap_src, rd_cap;

`ifdef SRAM_CTRL_INPUT_SYNC_EN
    // Pad input stage; RD_PULSE is stretched one cycle so this sample is taken with oe_n low.
    localparam logic RD_EXTRA = 1'b1;
    logic [DATA_W-1:0] dq_in_p1;
    always_ff @(posedge clk) dq_in_p1 <= sram_dq_in;
    assign cap_src = dq_in_p1;
`else
    localparam logic RD_EXTRA = 1'b0;
    assign cap_src = sram_dq_in;
`endif

    assign accept = req_valid & req_ready;

    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        turn_nx     = turn_cnt;
        op_we_nx    = op_we;
        rd_extra_nx = rd_extra;
        rd_done     = 1'b0;
        case (state)
            IDLE: if (accept) begin
                state_nx = SETUP;
                op_we_nx = req_we;
            end
            SETUP: begin
                cnt_nx = CNT_W'(WAIT_STATES);
                if (op_we) begin
                    state_nx = WR_PULSE;
                end else begin
                    state_nx    = RD_PULSE;
                    rd_extra_nx = RD_EXTRA;
                end
            end
            WR_PULSE: begin
                if (cnt != '0) cnt_nx = cnt - 1'b1;
                else           state_nx = WR_HOLD;
            end
            WR_HOLD: begin
                if (TURN_CYCLES > 0) begin
                    state_nx = TURN;
                    turn_nx  = TURN_W'(TURN_CYCLES - 1);
                end else begin
                    state_nx = IDLE;
                end
            end
            TURN: begin
                if (turn_cnt != '0) turn_nx = turn_cnt - 1'b1;
                else                state_nx = IDLE;
            end
            RD_PULSE: begin
                if (cnt != '0) begin
                    cnt_nx = cnt - 1'b1;
                end else if (rd_extra) begin
                    rd_extra_nx = 1'b0;
                end else begin
                    state_nx = IDLE;
                    rd_done  = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so every pad strobe comes straight off a flop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            cnt         <= '0;
            turn_cnt    <= '0;
            op_we       <= 1'b0;
            rd_extra    <= 1'b0;
            rd_pend     <= 1'b0;
            req_ready   <= 1'b0;
            busy        <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            sram_addr   <= '0;
            sram_dq_out <= '0;
            sram_ce_n   <= 1'b1;
            sram_oe_n   <= 1'b1;
            sram_we_n   <= 1'b1;
            sram_dq_oe  <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            turn_cnt  <= turn_nx;
            op_we     <= op_we_nx;
            rd_extra  <= rd_extra_nx;
            req_ready <= (state_nx == IDLE);
            busy      <= (state_nx != IDLE);
            {sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe} <= strobe_decode(state_nx, op_we_nx);
            if (accept) begin
                sram_addr <= req_addr;
                if (req_we) sram_dq_out <= req_wdata;
            end
            rd_pend   <= rd_done;
            rsp_valid <= rd_pend;
            if (rd_pend) rsp_rdata <= rd_cap;
        end
    end

    // Read capture stage
    always_ff @(posedge clk) begin
        if (rd_done) rd_cap <= cap_src;
    end

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed bench for sram_ctrl: three instances cover (WS=1,TC=1), (WS=0,TC=2), (WS=15,TC=1).
module tb_sram_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_we;
    logic [18:0] req_addr;
    logic [7:0]  req_wdata;
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic req_valid_a, req_ready_a, rsp_valid_a, busy_a, ce_n_a, oe_n_a, we_n_a, dq_oe_a;
    logic req_valid_b, req_ready_b, rsp_valid_b, busy_b, ce_n_b, oe_n_b, we_n_b, dq_oe_b;
    logic req_valid_c, req_ready_c, rsp_valid_c, busy_c, ce_n_c, oe_n_c, we_n_c, dq_oe_c;
    logic [7:0]  rsp_rdata_a, dq_out_a, dq_in_a;
    logic [7:0]  rsp_rdata_b, dq_out_b, dq_in_b;
    logic [7:0]  rsp_rdata_c, dq_out_c, dq_in_c;
    logic [18:0] sram_addr_a, sram_addr_b, sram_addr_c;
    logic [7:0]  mem_a [0:65535];
    logic [7:0]  mem_b [0:65535];
    logic [7:0]  mem_c [0:65535];

    sram_ctrl #(.ADDR_W(19), .DATA_W(8), .WAIT_STATES(1), .TURN_CYCLES(1)) dut_a (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid_a), .req_ready(req_ready_a),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid_a), .rsp_rdata(rsp_rdata_a), .busy(busy_a),
        .sram_addr(sram_addr_a), .sram_ce_n(ce_n_a), .sram_oe_n(oe_n_a), .sram_we_n(we_n_a),
        .sram_dq_oe(dq_oe_a), .sram_dq_out(dq_out_a), .sram_dq_in(dq_in_a));

    sram_ctrl #(.ADDR_W(19), .DATA_W(8), .WAIT_STATES(0), .TURN_CYCLES(2)) dut_b (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid_b), .req_ready(req_ready_b),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid_b), .rsp_rdata(rsp_rdata_b), .busy(busy_b),
        .sram_addr(sram_addr_b), .sram_ce_n(ce_n_b), .sram_oe_n(oe_n_b), .sram_we_n(we_n_b),
        .sram_dq_oe(dq_oe_b), .sram_dq_out(dq_out_b), .sram_dq_in(dq_in_b));

    sram_ctrl #(.ADDR_W(19), .DATA_W(8), .WAIT_STATES(15), .TURN_CYCLES(1)) dut_c (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid_c), .req_ready(req_ready_c),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid_c), .rsp_rdata(rsp_rdata_c), .busy(busy_c),
        .sram_addr(sram_addr_c), .sram_ce_n(ce_n_c), .sram_oe_n(oe_n_c), .sram_we_n(we_n_c),
        .sram_dq_oe(dq_oe_c), .sram_dq_out(dq_out_c), .sram_dq_in(dq_in_c));

    // SRAM models: preload 0x10..0x13 at addresses 0..3 during reset, write while we_n low.
    always @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) mem_a[i] <= 8'h10 + 8'(i);
        end else if (!ce_n_a && !we_n_a && dq_oe_a) mem_a[sram_addr_a[15:0]] <= dq_out_a;
    end
    always @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) mem_b[i] <= 8'h10 + 8'(i);
        end else if (!ce_n_b && !we_n_b && dq_oe_b) mem_b[sram_addr_b[15:0]] <= dq_out_b;
    end
    always @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) mem_c[i] <= 8'h10 + 8'(i);
        end else if (!ce_n_c && !we_n_c && dq_oe_c) mem_c[sram_addr_c[15:0]] <= dq_out_c;
    end
    assign dq_in_a = mem_a[sram_addr_a[15:0]];
    assign dq_in_b = mem_b[sram_addr_b[15:0]];
    assign dq_in_c = mem_c[sram_addr_c[15:0]];

    // Strobe invariants on every instance, every cycle.
    always @(negedge clk) begin
        checks++;
        if ((!we_n_a && !oe_n_a) || (dq_oe_a && !oe_n_a)) begin
            errors++;
            $display("FAIL inv_a: we_n=%b oe_n=%b dq_oe=%b at cyc %0d", we_n_a, oe_n_a, dq_oe_a, cyc);
        end
        checks++;
        if ((!we_n_b && !oe_n_b) || (dq_oe_b && !oe_n_b)) begin
            errors++;
            $display("FAIL inv_b: we_n=%b oe_n=%b dq_oe=%b at cyc %0d", we_n_b, oe_n_b, dq_oe_b, cyc);
        end
        checks++;
        if ((!we_n_c && !oe_n_c) || (dq_oe_c && !oe_n_c)) begin
            errors++;
            $display("FAIL inv_c: we_n=%b oe_n=%b dq_oe=%b at cyc %0d", we_n_c, oe_n_c, dq_oe_c, cyc);
        end
    end

    logic      mon_en = 1'b0;
    int        we_low = 0;
    logic [7:0] rq[$];
    int        tq[$];
    always @(negedge clk) begin
        if (mon_en) begin
            if (rsp_valid_a) begin
                rq.push_back(rsp_rdata_a);
                tq.push_back(cyc);
            end
            if (!we_n_a) we_low++;
        end
    end

    task automatic test_reset();
        reset_n = 1'b0;
        req_valid_a = 1'b0; req_valid_b = 1'b0; req_valid_c = 1'b0;
        req_we = 1'b0; req_addr = '0; req_wdata = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({req_ready_a, rsp_valid_a, busy_a, ce_n_a, oe_n_a, we_n_a, dq_oe_a} !== 7'b0001110) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 0001110",
                     {req_ready_a, rsp_valid_a, busy_a, ce_n_a, oe_n_a, we_n_a, dq_oe_a});
        end
        checks++;
        if ({sram_addr_a, rsp_rdata_a, dq_out_a} !== 35'd0) begin
            errors++;
            $display("FAIL reset_data: addr=%h rdata=%h dq_out=%h want 0", sram_addr_a, rsp_rdata_a, dq_out_a);
        end
        reset_n = 1'b1;
        #1;
        checks++;
        if (req_ready_a !== 1'b0) begin
            errors++;
            $display("FAIL ready_before_edge: got %b want 0", req_ready_a);
        end
        @(negedge clk);
        checks++;
        if ({req_ready_a, req_ready_b, req_ready_c} !== 3'b111) begin
            errors++;
            $display("FAIL ready_after_edge: got %b want 111", {req_ready_a, req_ready_b, req_ready_c});
        end
    endtask

    task automatic test_write();
        logic [7:0] we_v, oe_v, rdy_v, ce_v, busy_v;
        req_valid_a = 1'b1; req_we = 1'b1; req_addr = 19'h01234; req_wdata = 8'hA5;
        @(posedge clk);
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            we_v[j] = we_n_a; oe_v[j] = dq_oe_a; rdy_v[j] = req_ready_a;
            ce_v[j] = ce_n_a; busy_v[j] = busy_a;
            if (j == 0) begin
                req_valid_a = 1'b0; req_addr = 19'h7FFFF; req_wdata = 8'h00;
            end
            if (j == 2) begin
                checks++;
                if ({sram_addr_a, dq_out_a} !== {19'h01234, 8'hA5}) begin
                    errors++;
                    $display("FAIL wr_latch: addr=%h data=%h want 01234/a5", sram_addr_a, dq_out_a);
                end
            end
        end
        checks++;
        if (we_v !== 8'b11111001) begin errors++; $display("FAIL wr_we_n: got %b want 11111001", we_v); end
        checks++;
        if (oe_v !== 8'b00001111) begin errors++; $display("FAIL wr_dq_oe: got %b want 00001111", oe_v); end
        checks++;
        if (rdy_v !== 8'b11100000) begin errors++; $display("FAIL wr_ready: got %b want 11100000", rdy_v); end
        checks++;
        if (ce_v !== 8'b11110000) begin errors++; $display("FAIL wr_ce_n: got %b want 11110000", ce_v); end
        checks++;
        if (busy_v !== 8'b00011111) begin errors++; $display("FAIL wr_busy: got %b want 00011111", busy_v); end
        checks++;
        if (mem_a[16'h1234] !== 8'hA5) begin
            errors++;
            $display("FAIL wr_mem: got %h want a5", mem_a[16'h1234]);
        end
    endtask

    task automatic test_read();
        logic [7:0] rv_v, oe_n_v, dqoe_v;
        logic [7:0] data4;
        data4 = '0;
        req_valid_a = 1'b1; req_we = 1'b0; req_addr = 19'h01234;
        @(posedge clk);
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            rv_v[j] = rsp_valid_a; oe_n_v[j] = oe_n_a; dqoe_v[j] = dq_oe_a;
            if (j == 0) begin req_valid_a = 1'b0; req_addr = 19'h00000; end
            if (j == 4) data4 = rsp_rdata_a;
        end
        checks++;
        if (rv_v !== 8'b00010000) begin errors++; $display("FAIL rd_rsp_valid: got %b want 00010000", rv_v); end
        checks++;
        if (oe_n_v !== 8'b11111000) begin errors++; $display("FAIL rd_oe_n: got %b want 11111000", oe_n_v); end
        checks++;
        if (dqoe_v !== 8'b00000000) begin errors++; $display("FAIL rd_dq_oe: got %b want 00000000", dqoe_v); end
        checks++;
        if (data4 !== 8'hA5) begin errors++; $display("FAIL rd_data: got %h want a5", data4); end
        checks++;
        if (rsp_rdata_a !== 8'hA5) begin errors++; $display("FAIL rd_data_held: got %h want a5", rsp_rdata_a); end
    endtask

    task automatic test_turnaround();
        logic [11:0] ce_v, turn_v, rv_v, oe_n_v;
        logic [7:0]  data9;
        data9 = '0;
        req_valid_b = 1'b1; req_we = 1'b1; req_addr = 19'h00001; req_wdata = 8'h3C;
        @(posedge clk);
        for (int j = 0; j < 12; j++) begin
            @(negedge clk);
            ce_v[j] = ce_n_b; rv_v[j] = rsp_valid_b; oe_n_v[j] = oe_n_b;
            turn_v[j] = busy_b & ce_n_b & ~dq_oe_b;
            if (j == 0) begin req_we = 1'b0; req_wdata = 8'hFF; end
            if (j == 6) req_valid_b = 1'b0;
            if (j == 9) data9 = rsp_rdata_b;
        end
        checks++;
        if (turn_v !== 12'b000000011000) begin errors++; $display("FAIL ta_turn: got %b want 000000011000", turn_v); end
        checks++;
        if (ce_v !== 12'b111100111000) begin errors++; $display("FAIL ta_ce_n: got %b want 111100111000", ce_v); end
        checks++;
        if (oe_n_v !== 12'b111100111111) begin errors++; $display("FAIL ta_oe_n: got %b want 111100111111", oe_n_v); end
        checks++;
        if (rv_v !== 12'b001000000000) begin errors++; $display("FAIL ta_rsp_valid: got %b want 001000000000", rv_v); end
        checks++;
        if (data9 !== 8'h3C) begin errors++; $display("FAIL ta_data: got %h want 3c", data9); end
    endtask

    task automatic test_back_to_back();
        int t;
        rq.delete(); tq.delete(); we_low = 0;
        mon_en = 1'b1;
        req_we = 1'b0;
        for (int n = 0; n < 4; n++) begin
            req_addr = 19'(n);
            req_valid_a = 1'b1;
            t = 0;
            while (!req_ready_a && t < 20) begin @(negedge clk); t++; end
            checks++;
            if (t >= 20) begin errors++; $display("FAIL b2b_accept%0d: ready=%b want 1 within 20 cycles", n, req_ready_a); end
            @(negedge clk);
        end
        req_valid_a = 1'b0;
        repeat (8) @(negedge clk);
        mon_en = 1'b0;
        checks++;
        if (rq.size() != 4) begin errors++; $display("FAIL b2b_count: got %0d want 4", rq.size()); end
        for (int i = 0; i < rq.size() && i < 4; i++) begin
            checks++;
            if (rq[i] !== 8'h10 + 8'(i)) begin
                errors++;
                $display("FAIL b2b_data%0d: got %h want %h", i, rq[i], 8'h10 + 8'(i));
            end
            if (i > 0) begin
                checks++;
                if (tq[i] - tq[i-1] != 4) begin
                    errors++;
                    $display("FAIL b2b_gap%0d: got %0d want 4", i, tq[i] - tq[i-1]);
                end
            end
        end
        checks++;
        if (we_low != 0) begin errors++; $display("FAIL b2b_we_n: got %0d low cycles want 0", we_low); end
    endtask

    task automatic test_reset_mid_write();
        int rv_seen;
        req_valid_a = 1'b1; req_we = 1'b1; req_addr = 19'h00040; req_wdata = 8'h77;
        @(posedge clk);
        @(negedge clk);
        req_valid_a = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (we_n_a !== 1'b0) begin errors++; $display("FAIL rst_mid_pre: we_n=%b want 0", we_n_a); end
        reset_n = 1'b0;
        #1;
        checks++;
        if ({ce_n_a, we_n_a, oe_n_a, dq_oe_a, busy_a, req_ready_a} !== 6'b111000) begin
            errors++;
            $display("FAIL rst_mid_async: got %b want 111000", {ce_n_a, we_n_a, oe_n_a, dq_oe_a, busy_a, req_ready_a});
        end
        rv_seen = 0;
        repeat (2) begin @(negedge clk); if (rsp_valid_a) rv_seen++; end
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready_a !== 1'b1) begin errors++; $display("FAIL rst_mid_ready: got %b want 1", req_ready_a); end
        repeat (5) begin if (rsp_valid_a) rv_seen++; @(negedge clk); end
        checks++;
        if (rv_seen != 0) begin errors++; $display("FAIL rst_mid_rsp: got %0d pulses want 0", rv_seen); end
    endtask

    task automatic test_long_wait();
        int first, pulses, oe_low, exp_lat, exp_oe;
        logic [7:0] data;
`ifdef SRAM_CTRL_INPUT_SYNC_EN
        exp_lat = 19; exp_oe = 18;
`else
        exp_lat = 18; exp_oe = 17;
`endif
        first = -1; pulses = 0; oe_low = 0; data = '0;
        req_valid_c = 1'b1; req_we = 1'b0; req_addr = 19'h00002;
        @(posedge clk);
        for (int j = 0; j < 25; j++) begin
            @(negedge clk);
            if (j == 0) begin req_valid_c = 1'b0; req_addr = 19'h00003; end
            if (rsp_valid_c) begin
                pulses++;
                if (first < 0) begin first = j; data = rsp_rdata_c; end
            end
            if (!oe_n_c) oe_low++;
        end
        checks++;
        if (first != exp_lat) begin errors++; $display("FAIL ws15_latency: got %0d want %0d", first, exp_lat); end
        checks++;
        if (pulses != 1) begin errors++; $display("FAIL ws15_pulses: got %0d want 1", pulses); end
        checks++;
        if (data !== 8'h12) begin errors++; $display("FAIL ws15_data: got %h want 12", data); end
        checks++;
        if (oe_low != exp_oe) begin errors++; $display("FAIL ws15_oe_low: got %0d want %0d", oe_low, exp_oe); end
    endtask

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write();
        test_read();
        test_turnaround();
        test_back_to_back();
        test_reset_mid_write();
        test_long_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sram_ctrl.md
Name: sram_ctrl

Overview:
Parametrised controller for external asynchronous SRAM on the iCE40 boards. It replaces hard-wired CEn/OEn = 0 and WEn = !oe with registered, glitch-free strobes and programmable wait states. It adds write hold and bus turnaround, plus a valid/ready request port for the CPU or UART bridge. It sits between the core and the SB_IO data-pad array.

Parameters:
ADDR_W, 19, external address width (A0..A18)
DATA_W, 8, data bus width
WAIT_STATES, 1, extra strobe-low cycles beyond the first; legal 0..15
TURN_CYCLES, 1, idle cycles with bus released after every write; legal 0..3

Ports:
clk  in  1  single system clock
reset_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  controller accepts request this cycle
req_we  in  1  1 = write, 0 = read
req_addr  in  ADDR_W  word address
req_wdata  in  DATA_W  write data
rsp_valid  out  1  one-cycle pulse, rsp_rdata valid
rsp_rdata  out  DATA_W  read data, held until next read completes
busy  out  1  high whenever state != IDLE
sram_addr  out  ADDR_W  pad address
sram_ce_n  out  1  chip enable, active low
sram_oe_n  out  1  output enable, active low
sram_we_n  out  1  write enable, active low
sram_dq_oe  out  1  FPGA drives data pads
sram_dq_out  out  DATA_W  data to pads
sram_dq_in  in  DATA_W  data from pads

Behaviour:
- Clock and reset: one clock clk; reset_n is asynchronous and active-low. All outputs are registered.
- Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, busy=0, sram_addr=0, sram_ce_n=1, sram_oe_n=1, sram_we_n=1, sram_dq_oe=0, sram_dq_out=0.
- req_ready rises on the first clk edge after reset_n deasserts.
- req_ready is high only in IDLE. A request is accepted on an edge where req_valid & req_ready; req_ready drops on that same edge.
- Address and write data are latched at acceptance. The requester may change its inputs afterwards.
- States: IDLE, SETUP, WR_PULSE, WR_HOLD, TURN, RD_PULSE.
- IDLE -> SETUP on accept. SETUP lasts 1 cycle: ce_n=0, addr valid, we_n=1. For a read, oe_n=0 and dq_oe=0. For a write, dq_oe=1 and dq_out valid.
- Write path: SETUP -> WR_PULSE, which lasts WAIT_STATES+1 cycles with we_n=0. Then WR_HOLD for 1 cycle: we_n=1, data still driven, ce_n=0.
- After WR_HOLD: to TURN if TURN_CYCLES>0, else to IDLE. TURN lasts TURN_CYCLES cycles with ce_n=1, dq_oe=0.
- Write occupancy is WAIT_STATES+3+TURN_CYCLES cycles from the acceptance edge until req_ready=1.
- Read path: SETUP -> RD_PULSE, which lasts WAIT_STATES+1 cycles with oe_n=0. sram_dq_in is captured on the edge ending the last RD_PULSE cycle. Next state IDLE.
- Read response: rsp_valid is high for exactly the one cycle after capture. Latency from the acceptance edge to rsp_valid high is WAIT_STATES+3 cycles.
- Consecutive reads issue back-to-back through IDLE with no turnaround.
- Invariants:
  - we_n and oe_n are never low in the same cycle.
  - dq_oe is never 1 while oe_n=0.
  - we_n changes only while addr is stable.
- The wait counter is 4 bits. It loads WAIT_STATES on entry to a pulse state and decrements to 0; there is no wrap.
- Reset mid-access: all strobes go inactive and dq_oe releases immediately (asynchronously). The in-flight access is discarded and no rsp_valid is issued.
- req_valid asserted while busy is ignored; it must be held by the requester.

Optional Feature:
Macro SRAM_CTRL_INPUT_SYNC_EN.
- Defined: sram_dq_in passes through one extra register stage before capture. The extra stage isolates pad timing at high ring-oscillator clock rates. Read latency becomes WAIT_STATES+4 cycles, and RD_PULSE keeps oe_n low one extra cycle so the registered sample is valid. Write timing is unchanged.
- Undefined: direct capture as above.

Decomposition:
- Package sram_ctrl_pkg: state encoding localparams (IDLE..RD_PULSE), wait counter width constant (4), TURN counter width constant (2).
- Sub-module sram_ctrl_dq_io: DATA_W-wide SB_IO bidirectional pad array (PIN_TYPE 6'b101001, no pull-up). It takes dq_oe/dq_out/dq_in and instantiates per-bit from a generate loop. The controller itself stays technology-independent.

Test Plan:
1. Reset, then write addr 0x1234 data 0xA5 with WAIT_STATES=1, TURN_CYCLES=1 -> required response:
   - we_n low for exactly 2 cycles;
   - dq_oe=1 from SETUP through WR_HOLD;
   - req_ready back high 5 cycles after acceptance;
   - SRAM model holds 0xA5 at 0x1234.
2. Read 0x1234 -> rsp_valid single pulse 4 cycles after acceptance with rsp_rdata=0xA5; oe_n low 3 cycles; dq_oe=0 throughout.
3. Write 0x0001=0x3C, read 0x0001, WAIT_STATES=0, TURN_CYCLES=2 -> required response:
   - 2 cycles with ce_n=1, dq_oe=0 between WR_HOLD and the read SETUP;
   - rsp_rdata=0x3C.
4. Four back-to-back reads 0x0000..0x0003 (model data 0x10..0x13), req_valid held high -> required response:
   - four rsp_valid pulses with rsp_rdata=0x10..0x13;
   - no turnaround cycles;
   - we_n stays 1.
5. Assert reset_n low during the second cycle of WR_PULSE -> required response:
   - ce_n/we_n/oe_n=1 and dq_oe=0 asynchronously;
   - no rsp_valid;
   - req_ready=1 one edge after release.
6. WAIT_STATES=15 read with SRAM_CTRL_INPUT_SYNC_EN defined -> rsp_valid exactly 19 cycles after acceptance with correct data; throughout all tests, the checker asserts the we_n/oe_n and dq_oe/oe_n invariants.
